fifo_reader: RTL and testbench

Burst reader for the consumer side of the FIFO's valid/ready output interface (data_out / data_out_vld / data_out_rdy).
- On a start command, pulls exactly LEN words from the FIFO and accumulates a modular sum checksum and word count.
- Flags a timeout if the FIFO stays empty too long.
- Used as the drain agent in full/empty stress scenarios and as the sink stage in integration builds.

---
 rtl/fifo_reader.sv | 130 +++++++++++++
 tb/tb_fifo_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Burst reader for a FIFO valid/ready output: takes exactly len words and accumulates a checksum.
// Optional `define THROTTLE_EN adds a GAP state that holds rdy low for gap cycles after each non-final word.
//
//   state  | meaning
//   S_IDLE | waiting for start; rdy low
//   S_READ | rdy high, accepting words, timeout timer running
//   S_GAP  | rdy low for gap cycles between words (THROTTLE_EN only)
//   S_DONE | one-cycle done pulse, then back to S_IDLE
module fifo_reader #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 16,
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_vld,
  output logic              data_out_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  word_cnt,
  output logic [DATA_W-1:0] checksum
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT - 1);

`ifdef THROTTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_DONE} state_t;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
  logic unused_gap;
  assign unused_gap = ^gap;
`endif

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= '0;
      tmr          <= '0;
      word_cnt     <= '0;
      checksum     <= '0;
      err          <= 1'b0;
      data_out_rdy <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef THROTTLE_EN
      gap_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            word_cnt <= '0;
            checksum <= '0;
            err      <= 1'b0;
            tmr      <= TMR_INIT;
            busy     <= 1'b1;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_READ;
              data_out_rdy <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (data_out_vld) begin
            word_cnt <= word_cnt + LEN_W'(1);
            checksum <= checksum + data_out;
            tmr      <= TMR_INIT;
            if (word_cnt + LEN_W'(1) == len_q) begin
              state        <= S_DONE;
              data_out_rdy <= 1'b0;
              done         <= 1'b1;
            end
`ifdef THROTTLE_EN
            else if (gap != '0) begin
              state        <= S_GAP;
              gap_cnt      <= gap - GAP_W'(1);
              data_out_rdy <= 1'b0;
            end
`endif
          end else if (tmr == '0) begin
            // FIFO empty for TIMEOUT consecutive READ cycles
            err          <= 1'b1;
            state        <= S_DONE;
            data_out_rdy <= 1'b0;
            done         <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
`ifdef THROTTLE_EN
        S_GAP: begin
          if (gap_cnt == '0) begin
            state        <= S_READ;
            data_out_rdy <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          data_out_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO model, directed cases plus randomized bursts.
// Builds with or without `define THROTTLE_EN.
module tb_fifo_reader;
  localparam int DW = 8, LW = 16, GW = 4, TO = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [GW-1:0] gap = '0;
  logic [DW-1:0] data_out = '0;
  logic          data_out_vld = 1'b0;
  logic          data_out_rdy, busy, done, err;
  logic [LW-1:0] word_cnt;
  logic [DW-1:0] checksum;

  fifo_reader #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .gap(gap),
    .data_out(data_out), .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  bit            stall = 1'b0;
  int            rdy_hi, hs_cnt, vec = 0, errs = 0;
  logic [31:0]   rdy_hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: present FIFO head, pop on handshake, return at the falling edge.
  task automatic cyc();
    bit hs;
    data_out_vld = (q.size() > 0) && !stall;
    if (q.size() > 0) data_out = q[0];
    else data_out = '0;
    hs = data_out_vld && data_out_rdy;
    if (data_out_rdy) rdy_hi++;
    rdy_hist = {rdy_hist[30:0], data_out_rdy};
    @(posedge clk);
    if (hs) begin
      void'(q.pop_front());
      hs_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic kick(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    cyc();
    start  = 1'b0;
    rdy_hi = 0;
    hs_cnt = 0;
    rdy_hist = '0;
  endtask

  task automatic wait_done(input int push_at, input bit stall_en, input bit poke, output int n);
    n = 0;
    while (!done && n < 200) begin
      if (n == push_at) q.push_back(8'h5A);
      stall = stall_en && ($urandom_range(0, 3) == 0);
      if (poke && n == 1) begin
        start = 1'b1;
        len   = LW'($urandom_range(1, 50));
      end
      cyc();
      start = 1'b0;
      n++;
    end
    stall = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  int n, k, l, sum;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, data_out_rdy}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_wc", 32'(word_cnt), 0);
    chk("rst_cs", 32'(checksum), 0);
    rst = 1'b0;
    @(negedge clk);

    // len=4 from 01..05: back-to-back, fifth word left behind
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    kick(4);
    chk("b4_rdy_first", {31'd0, data_out_rdy}, 1);
    wait_done(-1, 0, 0, n);
    chk("b4_latency", n, 4);
    chk("b4_rdy_cycles", rdy_hi, 4);
    chk("b4_wc", 32'(word_cnt), 4);
    chk("b4_cs", 32'(checksum), 32'h0A);
    chk("b4_err", {31'd0, err}, 0);
    chk("b4_left", q.size(), 1);
    cyc();
    chk("b4_idle", {31'd0, busy}, 0);
    chk("b4_hold_wc", 32'(word_cnt), 4);
    chk("b4_hold_cs", 32'(checksum), 32'h0A);

    // len=0
    kick(0);
    wait_done(-1, 0, 0, n);
    chk("z_latency", n, 0);
    chk("z_rdy", rdy_hi, 0);
    chk("z_wc", 32'(word_cnt), 0);
    chk("z_cs", 32'(checksum), 0);
    chk("z_err", {31'd0, err}, 0);
    cyc();

    // checksum wrap
    q = '{8'hFF, 8'h02};
    kick(2);
    wait_done(-1, 0, 0, n);
    chk("wrap_cs", 32'(checksum), 32'h01);
    chk("wrap_wc", 32'(word_cnt), 2);
    cyc();

    // timeout on empty FIFO
    q.delete();
    kick(3);
    wait_done(-1, 0, 0, n);
    chk("to_cycles", n, TO);
    chk("to_rdy", rdy_hi, TO);
    chk("to_err", {31'd0, err}, 1);
    chk("to_wc", 32'(word_cnt), 0);
    cyc();
    chk("to_err_held", {31'd0, err}, 1);

    // one word arrives after 10 empty cycles; timer restarts
    kick(3);
    wait_done(10, 0, 0, n);
    chk("to2_cycles", n, 11 + TO);
    chk("to2_err", {31'd0, err}, 1);
    chk("to2_wc", 32'(word_cnt), 1);
    chk("to2_cs", 32'(checksum), 32'h5A);
    cyc();

    // start while busy must not disturb the burst
    q = '{8'h11, 8'h22, 8'h33};
    kick(3);
    wait_done(-1, 0, 1, n);
    chk("busy_start_wc", 32'(word_cnt), 3);
    chk("busy_start_cs", 32'(checksum), 32'h66);
    cyc();

`ifdef THROTTLE_EN
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    gap = 4'd3;
    kick(3);
    wait_done(-1, 0, 0, n);
    chk("gap_cycles", n, 9);
    chk("gap_pattern", rdy_hist & 32'h1FF, 32'b100010001);
    chk("gap_left", q.size(), 1);
    gap = '0;
    cyc();
`endif

    // async reset mid-burst after 2 of 5 words
    q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    kick(5);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_rdy", {31'd0, data_out_rdy}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_wc", 32'(word_cnt), 0);
    chk("mrst_cs", 32'(checksum), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_left", q.size(), 3);
    kick(3);
    wait_done(-1, 0, 0, n);
    chk("mrst_wc2", 32'(word_cnt), 3);
    chk("mrst_cs2", 32'(checksum), 120);
    cyc();

    // randomized bursts with FIFO stalls and stray starts
    for (int it = 0; it < 20; it++) begin
      q.delete();
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) q.push_back(DW'($urandom));
      l = $urandom_range(0, k);
      sum = 0;
      for (int j = 0; j < l; j++) sum += int'(q[j]);
`ifndef THROTTLE_EN
      gap = GW'($urandom);
`endif
      kick(LW'(l));
      wait_done(-1, 1, 1, n);
      chk("rnd_wc", 32'(word_cnt), l);
      chk("rnd_cs", 32'(checksum), sum % 256);
      chk("rnd_err", {31'd0, err}, 0);
      chk("rnd_hs", hs_cnt, l);
      chk("rnd_left", q.size(), k - l);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
